// File: rtl/hs_reg_slice.sv
// -----------------------------------------------------------------------------
// hs_reg_slice
//
// Fully registered valid/ready pipeline stage (skid buffer). Two storage
// entries: the main register M, which always drives dat_o, and the skid
// register S, which catches the one word that can arrive in the cycle the
// downstream stalls. Every output comes straight from a flop, so this stage
// cuts all timing paths between upstream and downstream, in both the data
// and the handshake directions, while still sustaining one transfer per cycle.
//
// Occupancy states:
//   EMPTY : nothing stored          valid_o=0 ready_o=1 cnt_o=0
//   ONE   : M holds the head word   valid_o=1 ready_o=1 cnt_o=1
//   FULL  : M = head, S = next      valid_o=1 ready_o=0 cnt_o=2
// -----------------------------------------------------------------------------
module hs_reg_slice #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   // upstream side
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [DATA_WIDTH-1:0] dat_i,
   // downstream side
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] dat_o,
   // occupancy
   output logic [1:0]            cnt_o
);

   // State encoding equals the occupancy, so cnt_o is the state register.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  valid_q, valid_d;
   logic                  ready_q, ready_d;
   logic [DATA_WIDTH-1:0] m_q, s_q;

   // Data-path controls produced by the state logic.
   logic                  load_m;      // write M this cycle
   logic                  m_from_s;    // M source: 1 = skid register, 0 = dat_i
   logic                  load_s;      // write S this cycle

   logic                  in_fire;
   logic                  out_fire;

   // Handshakes are judged on the registered outputs, never on a
   // combinational function of the inputs, so valid_i is naturally ignored
   // while ready_o is low and dat_i is only sampled on an in-fire.
   assign in_fire  = valid_i & ready_q;
   assign out_fire = valid_q & ready_i;

   // Next-state and data-steering decisions for the occupancy FSM.
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // through the block leaves it unassigned; otherwise a latch is inferred.
      state_d  = state_q;
      load_m   = 1'b0;
      m_from_s = 1'b0;
      load_s   = 1'b0;

      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               load_m  = 1'b1;
               state_d = ST_ONE;
            end
         end

         ST_ONE: begin
            if (in_fire && out_fire) begin
               // Head leaves and the new word takes its place.
               load_m = 1'b1;
            end else if (in_fire) begin
               // Downstream stalled: park the new word behind the head.
               load_s  = 1'b1;
               state_d = ST_FULL;
            end else if (out_fire) begin
               // M is left as is; its contents are meaningless once empty.
               state_d = ST_EMPTY;
            end
         end

         ST_FULL: begin
            // ready_o is low here, so no in-fire can occur.
            if (out_fire) begin
               load_m   = 1'b1;
               m_from_s = 1'b1;
               state_d  = ST_ONE;
            end
         end

         default: begin
            // Unreachable encoding: recover to a clean, empty slice.
            state_d = ST_EMPTY;
         end
      endcase
   end

   // Output handshake flags for the next cycle follow from the next state.
   always_comb begin
      valid_d = (state_d != ST_EMPTY);
      ready_d = (state_d != ST_FULL);
   end

   // Control state and registered handshake outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         // NOTE: sequential state is updated with non-blocking assignments so
         // every flop samples the pre-edge values, independent of statement order.
         state_q <= state_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
      end
   end

   // Main register M: loaded from dat_i or promoted from the skid register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         // NOTE: the payload registers are reset too, so dat_o reads 0 while in
         // reset and no word from before reset can ever reappear afterwards.
         m_q <= '0;
      end else if (load_m) begin
         m_q <= m_from_s ? s_q : dat_i;
      end
   end

   // Skid register S: captures the word that arrives during a downstream stall.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s_q <= '0;
      end else if (load_s) begin
         s_q <= dat_i;
      end
   end

   assign valid_o = valid_q;
   assign ready_o = ready_q;
   assign dat_o   = m_q;
   assign cnt_o   = state_q;

endmodule

// File: tb/tb_hs_reg_slice.sv
// -----------------------------------------------------------------------------
// tb_hs_reg_slice
//
// Self-checking bench for hs_reg_slice. Inputs change 1 ns after each rising
// edge and outputs are compared 1 ns after the edge that consumed them.
// A directed vector table covers streaming, backpressure and simultaneous
// fire; hand-written sequences cover reset, reset in FULL and random traffic
// against a queue model.
// -----------------------------------------------------------------------------
module tb_hs_reg_slice;

   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          valid_i;
   logic          ready_o;
   logic [DW-1:0] dat_i;
   logic          valid_o;
   logic          ready_i;
   logic [DW-1:0] dat_o;
   logic [1:0]    cnt_o;

   int checks = 0;
   int errors = 0;

   hs_reg_slice #(.DATA_WIDTH(DW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .dat_i   (dat_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .dat_o   (dat_o),
      .cnt_o   (cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outs(input string tag, input logic e_vld, input logic e_rdy,
                             input logic [1:0] e_cnt, input logic chk_dat,
                             input logic [DW-1:0] e_dat);
      check({tag, ".valid_o"}, DW'(valid_o), DW'(e_vld));
      check({tag, ".ready_o"}, DW'(ready_o), DW'(e_rdy));
      check({tag, ".cnt_o"},   DW'(cnt_o),   DW'(e_cnt));
      if (chk_dat) check({tag, ".dat_o"}, dat_o, e_dat);
   endtask

   // One step: inputs applied now, outputs compared 1 ns after the next edge.
   task automatic step(input logic vld, input logic [DW-1:0] dat, input logic rdy);
      valid_i = vld;
      dat_i   = dat;
      ready_i = rdy;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          vld;
      logic [DW-1:0] dat;
      logic          rdy;
      logic          e_vld;
      logic          e_rdy;
      logic [1:0]    e_cnt;
      logic          chk_dat;
      logic [DW-1:0] e_dat;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic vld, input logic [DW-1:0] dat,
                               input logic rdy, input logic e_vld, input logic e_rdy,
                               input logic [1:0] e_cnt, input logic chk_dat,
                               input logic [DW-1:0] e_dat);
      vec_t v;
      v.vld = vld; v.dat = dat; v.rdy = rdy;
      v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
      v.chk_dat = chk_dat; v.e_dat = e_dat;
      vecs.push_back(v);
   endfunction

   initial begin
      logic [DW-1:0] model_q[$];
      logic          held_vld;
      logic [DW-1:0] held_dat;
      logic          in_fire, out_fire;

      // ---------------- reset with valid_i=1, dat_i=0xA5 ----------------
      rst_n   = 1'b1;
      valid_i = 1'b1;
      dat_i   = 32'hA5;
      ready_i = 1'b1;
      #1 rst_n = 1'b0;
      #1 check_outs("rst_async", 1'b0, 1'b1, 2'd0, 1'b1, '0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check_outs("rst_hold", 1'b0, 1'b1, 2'd0, 1'b1, '0);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      valid_i = 1'b0;
      @(posedge clk);
      #1 check_outs("rst_nothing_captured", 1'b0, 1'b1, 2'd0, 1'b1, '0);

      // ---------------- directed vector table ----------------
      //   vld  dat    rdy  e_vld e_rdy e_cnt chk  e_dat
      // streaming, ready_i=1
      add(1, 32'h1,  1,   1,    1,    1,    1,   32'h1);
      add(1, 32'h2,  1,   1,    1,    1,    1,   32'h2);
      add(1, 32'h3,  1,   1,    1,    1,    1,   32'h3);
      add(0, 32'h0,  1,   0,    1,    0,    0,   32'h0);
      // backpressure, 0x12 attempted while full
      add(1, 32'h10, 0,   1,    1,    1,    1,   32'h10);
      add(1, 32'h11, 0,   1,    0,    2,    1,   32'h10);
      add(1, 32'h12, 0,   1,    0,    2,    1,   32'h10);
      add(1, 32'h12, 0,   1,    0,    2,    1,   32'h10);
      add(0, 32'h0,  1,   1,    1,    1,    1,   32'h11);
      add(0, 32'h0,  1,   0,    1,    0,    0,   32'h0);
      // simultaneous fire starting in FULL
      add(1, 32'h30, 0,   1,    1,    1,    1,   32'h30);
      add(1, 32'h31, 0,   1,    0,    2,    1,   32'h30);
      add(1, 32'h32, 1,   1,    1,    1,    1,   32'h31); // ready_o was 0: no in-fire
      add(1, 32'h32, 1,   1,    1,    1,    1,   32'h32); // in and out fire together
      add(0, 32'h0,  1,   0,    1,    0,    0,   32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].vld, vecs[i].dat, vecs[i].rdy);
         check_outs($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_rdy,
                    vecs[i].e_cnt, vecs[i].chk_dat, vecs[i].e_dat);
      end

      // ---------------- reset mid-operation in FULL ----------------
      step(1'b1, 32'h20, 1'b0);
      step(1'b1, 32'h21, 1'b0);
      check_outs("full_before_rst", 1'b1, 1'b0, 2'd2, 1'b1, 32'h20);
      valid_i = 1'b0;
      #3 rst_n = 1'b0;                       // between edges
      #1 check_outs("midrst_async", 1'b0, 1'b1, 2'd0, 1'b1, '0);
      @(posedge clk);
      #1 check_outs("midrst_hold", 1'b0, 1'b1, 2'd0, 1'b1, '0);
      ready_i = 1'b1;
      #3 rst_n = 1'b1;                       // release between edges
      // first edge after release must already accept a word
      step(1'b1, 32'h40, 1'b1);
      check_outs("first_fire_after_rst", 1'b1, 1'b1, 2'd1, 1'b1, 32'h40);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 32'h0, 1'b1);
         check_outs("no_stale_after_rst", 1'b0, 1'b1, 2'd0, 1'b0, '0);
         check("no_stale_dat", DW'((dat_o == 32'h20) || (dat_o == 32'h21)), '0);
      end

      // ---------------- random traffic against a queue model ----------------
      for (int cyc = 0; cyc < 10000; cyc++) begin
         valid_i  = ($urandom_range(0, 99) < 60);
         ready_i  = ($urandom_range(0, 99) < 55);
         dat_i    = $urandom;
         in_fire  = valid_i & ready_o;
         out_fire = valid_o & ready_i;
         held_vld = valid_o & ~ready_i;
         held_dat = dat_o;
         if (out_fire) begin
            if (model_q.size() == 0) begin
               check("rnd_spurious_out", 32'd1, 32'd0);
            end else begin
               check("rnd_order", dat_o, model_q.pop_front());
            end
         end
         if (in_fire) model_q.push_back(dat_i);
         @(posedge clk);
         #1;
         check("rnd_cnt", DW'(cnt_o), DW'(model_q.size()));
         check("rnd_valid", DW'(valid_o), DW'(model_q.size() != 0));
         check("rnd_ready", DW'(ready_o), DW'(model_q.size() < 2));
         if (held_vld) begin
            check("rnd_stall_valid", DW'(valid_o), 32'd1);
            check("rnd_stall_dat", dat_o, held_dat);
         end
      end

      // drain whatever remains and confirm nothing was lost
      valid_i = 1'b0;
      ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (valid_o) begin
            if (model_q.size() == 0) check("drain_spurious", 32'd1, 32'd0);
            else check("drain_order", dat_o, model_q.pop_front());
         end
         @(posedge clk);
         #1;
      end
      check("drain_model_empty", DW'(model_q.size()), 32'd0);
      check_outs("drain_end", 1'b0, 1'b1, 2'd0, 1'b0, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hs_reg_slice.md
HS_REG_SLICE -- requirements
Module: hs_reg_slice

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits (legal range 1..1024).
REQ-002 The module SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n_i, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 The module SHALL have port valid_i, input, 1 bit, upstream data valid.
REQ-005 The module SHALL have port ready_o, output, 1 bit, slice able to accept upstream data.
REQ-006 The module SHALL have port dat_i, input, DATA_WIDTH bits, upstream payload.
REQ-007 The module SHALL have port valid_o, output, 1 bit, downstream data valid.
REQ-008 The module SHALL have port ready_i, input, 1 bit, downstream able to accept data.
REQ-009 The module SHALL have port dat_o, output, DATA_WIDTH bits, downstream payload.
REQ-010 The module SHALL have port cnt_o, output, 2 bits, current occupancy (0, 1 or 2).

Function
REQ-011 The module SHALL define in-fire as valid_i & ready_o and out-fire as valid_o & ready_i, both sampled at the rising clk_i edge.
REQ-012 The module SHALL hold two storage entries: main register M (drives dat_o) and skid register S.
REQ-013 The module SHALL implement three states: EMPTY (cnt_o=0), ONE (M valid, cnt_o=1) and FULL (M and S valid, cnt_o=2).
REQ-014 valid_o, ready_o, dat_o and cnt_o SHALL each be driven directly from flops, with no combinational path from any input.
REQ-015 In all states, valid_o SHALL equal (state != EMPTY), ready_o SHALL equal (state != FULL) and dat_o SHALL equal M.
REQ-016 In EMPTY, in-fire SHALL load M with dat_i and move to ONE; otherwise the module SHALL stay in EMPTY.
REQ-017 In ONE, in-fire with out-fire SHALL load M with dat_i and stay in ONE.
REQ-018 In ONE, in-fire without out-fire SHALL load S with dat_i and move to FULL, leaving M unchanged.
REQ-019 In ONE, out-fire without in-fire SHALL move to EMPTY, leaving M contents don't-care.
REQ-020 In FULL, out-fire SHALL copy S into M and move to ONE; with no out-fire the module SHALL hold state, M and S.
REQ-021 Latency from in-fire to valid_o high SHALL be exactly 1 cycle, and sustained throughput SHALL be 1 transfer per cycle while ready_i stays high.
REQ-022 Data SHALL leave the module in strict arrival order, with no loss and no duplication.
REQ-023 Once valid_o is high, valid_o and dat_o SHALL stay stable until out-fire occurs.
REQ-024 dat_i SHALL be ignored whenever in-fire is low, and valid_i SHALL be ignored whenever ready_o is low.

Reset
REQ-025 Asserting rst_n_i low SHALL immediately, without waiting for a clock edge, force EMPTY, valid_o=0, ready_o=1, cnt_o=0 and dat_o=0.
REQ-026 S SHALL reset to 0.
REQ-027 Reset asserted during any state, including FULL, SHALL discard all stored data, and no stale word SHALL appear after release.
REQ-028 The first in-fire SHALL be possible on the first rising clk_i edge after rst_n_i deasserts.

Verification
REQ-029 The bench SHALL cover reset: rst_n_i low with valid_i=1 and dat_i=0xA5 -> valid_o=0, ready_o=1, cnt_o=0, dat_o=0 throughout, and nothing captured.
REQ-030 The bench SHALL cover streaming: ready_i=1, with 0x1,0x2,0x3 presented on consecutive cycles -> the same values appear on dat_o with valid_o high 1 cycle later each, cnt_o=1 throughout and ready_o=1.
REQ-031 The bench SHALL cover backpressure: ready_i=0, with 0x10 then 0x11 in-fired -> cnt_o=2, ready_o=0 and dat_o=0x10; an attempted 0x12 is not accepted; then ready_i=1 -> 0x10 then 0x11 out, cnt_o 2->1->0.
REQ-032 The bench SHALL cover simultaneous fire: in FULL with ready_i=1 and valid_i=1 -> no in-fire on the ready_o=0 cycle; on the next cycle ready_o=1, so in-fire and out-fire occur together and cnt_o stays 1.
REQ-033 The bench SHALL cover reset mid-operation: in FULL holding 0x20 and 0x21, pulse rst_n_i low between clock edges -> outputs take reset values immediately, and after release with ready_i=1 neither 0x20 nor 0x21 appears.
REQ-034 The bench SHALL cover random traffic: random valid_i/ready_i for 10k cycles -> a scoreboard shows ordering and no loss, and valid_o/dat_o stay stable while stalled.
